// File: rtl/keypad_encoder.sv
// Registered keypad front end: per-input debounce, priority keycode encode,
// press/release pulses, saturating octave register and wrapping mode register.

module keypad_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the accepted level restarts the count,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples is taken.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (raw_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = raw_i;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

module keypad_encoder #(
    parameter int unsigned NUM_KEYS        = 17,
    parameter int unsigned CODE_W          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OCTAVE_MIN      = 0,
    parameter int unsigned OCTAVE_MAX      = 7,
    parameter int unsigned OCTAVE_RESET    = 4,
    parameter int unsigned NUM_MODES       = 4,
    localparam int unsigned OCT_W          = $clog2(OCTAVE_MAX + 1),
    localparam int unsigned MODE_W         = $clog2(NUM_MODES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] sync_keys_i,
    input  logic                octave_up_key_i,
    input  logic                octave_down_key_i,
    input  logic                mode_key_i,
    output logic [CODE_W-1:0]   keycode_o,
    output logic                strobe_o,
    output logic                key_press_o,
    output logic                key_release_o,
    output logic [OCT_W-1:0]    octave_o,
    output logic [MODE_W-1:0]   mode_o
);

    localparam int unsigned NUM_RAW = NUM_KEYS + 3;
    localparam int unsigned IDX_UP  = NUM_KEYS;
    localparam int unsigned IDX_DN  = NUM_KEYS + 1;
    localparam int unsigned IDX_MD  = NUM_KEYS + 2;

    localparam logic [OCT_W-1:0]  OCT_MIN_V   = OCT_W'(OCTAVE_MIN);
    localparam logic [OCT_W-1:0]  OCT_MAX_V   = OCT_W'(OCTAVE_MAX);
    localparam logic [OCT_W-1:0]  OCT_RST_V   = OCT_W'(OCTAVE_RESET);
    localparam logic [MODE_W-1:0] MODE_LAST_V = MODE_W'(NUM_MODES - 1);

    logic [NUM_RAW-1:0]  raw_all;
    logic [NUM_RAW-1:0]  deb_all;
    logic [NUM_KEYS-1:0] deb_keys;
    logic                deb_up, deb_dn, deb_md;

    logic [CODE_W-1:0] keycode_q, keycode_d;
    logic              strobe_q, strobe_d;
    logic              key_press_q, key_press_d;
    logic              key_release_q, key_release_d;
    logic [OCT_W-1:0]  octave_q, octave_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              up_hist_q, dn_hist_q, md_hist_q;

    logic up_edge, dn_edge, md_edge;

    assign raw_all = {mode_key_i, octave_down_key_i, octave_up_key_i, sync_keys_i};

    for (genvar g = 0; g < NUM_RAW; g++) begin : g_deb
        keypad_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (raw_all[g]),
            .stable_o (deb_all[g])
        );
    end

    assign deb_keys = deb_all[NUM_KEYS-1:0];
    assign deb_up   = deb_all[IDX_UP];
    assign deb_dn   = deb_all[IDX_DN];
    assign deb_md   = deb_all[IDX_MD];

    // Ascending scan so the highest pressed index wins.
    always_comb begin
        keycode_d = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (deb_keys[i]) begin
                keycode_d = CODE_W'(i + 1);
            end
        end
    end

    always_comb begin
        strobe_d      = |deb_keys;
        key_press_d   = (keycode_d != '0) && (keycode_d != keycode_q);
        key_release_d = (keycode_d == '0) && (keycode_q != '0);
    end

    assign up_edge = deb_up & ~up_hist_q;
    assign dn_edge = deb_dn & ~dn_hist_q;
    assign md_edge = deb_md & ~md_hist_q;

    always_comb begin
        octave_d = octave_q;
        if (up_edge && !dn_edge) begin
            if (octave_q < OCT_MAX_V) begin
                octave_d = octave_q + 1'b1;
            end
        end else if (dn_edge && !up_edge) begin
            if (octave_q > OCT_MIN_V) begin
                octave_d = octave_q - 1'b1;
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (md_edge) begin
            mode_d = (mode_q == MODE_LAST_V) ? '0 : mode_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keycode_q     <= '0;
            strobe_q      <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            octave_q      <= OCT_RST_V;
            mode_q        <= '0;
            up_hist_q     <= 1'b0;
            dn_hist_q     <= 1'b0;
            md_hist_q     <= 1'b0;
        end else begin
            keycode_q     <= keycode_d;
            strobe_q      <= strobe_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            octave_q      <= octave_d;
            mode_q        <= mode_d;
            up_hist_q     <= deb_up;
            dn_hist_q     <= deb_dn;
            md_hist_q     <= deb_md;
        end
    end

    assign keycode_o     = keycode_q;
    assign strobe_o      = strobe_q;
    assign key_press_o   = key_press_q;
    assign key_release_o = key_release_q;
    assign octave_o      = octave_q;
    assign mode_o        = mode_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with default parameters (17 keys, 4-cycle debounce).

module tb_keypad_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] keys;
    logic        up, dn, md;
    logic [4:0]  keycode;
    logic        strobe, press, release_p;
    logic [2:0]  octave;
    logic [1:0]  mode;

    int tests  = 0;
    int failed = 0;

    keypad_encoder dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .sync_keys_i       (keys),
        .octave_up_key_i   (up),
        .octave_down_key_i (dn),
        .mode_key_i        (md),
        .keycode_o         (keycode),
        .strobe_o          (strobe),
        .key_press_o       (press),
        .key_release_o     (release_p),
        .octave_o          (octave),
        .mode_o            (mode)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_notes(input string tag, input int kc, input int st, input int pr, input int rl);
        chk({tag, ".keycode"}, int'(keycode), kc);
        chk({tag, ".strobe"}, int'(strobe), st);
        chk({tag, ".press"}, int'(press), pr);
        chk({tag, ".release"}, int'(release_p), rl);
    endtask

    task automatic press_up();
        up = 1'b1; tick(5);
        up = 1'b0; tick(5);
    endtask

    task automatic press_dn();
        dn = 1'b1; tick(5);
        dn = 1'b0; tick(5);
    endtask

    task automatic press_md();
        md = 1'b1; tick(5);
        md = 1'b0; tick(5);
    endtask

    initial begin
        int exp_oct;
        int glitch_seen;

        rst = 1'b1; keys = '0; up = 1'b0; dn = 1'b0; md = 1'b0;
        tick(2);
        chk_notes("rst0", 0, 0, 0, 0);
        chk("rst0.octave", int'(octave), 4);
        chk("rst0.mode", int'(mode), 0);
        rst = 1'b0;
        tick(1);

        // 1: single key press/release latency
        keys[0] = 1'b1;
        tick(4);
        chk_notes("t1.pre", 0, 0, 0, 0);
        tick(1);
        chk_notes("t1.on", 1, 1, 1, 0);
        tick(1);
        chk_notes("t1.hold", 1, 1, 0, 0);
        keys[0] = 1'b0;
        tick(4);
        chk_notes("t1.relpre", 1, 1, 0, 0);
        tick(1);
        chk_notes("t1.off", 0, 0, 0, 1);
        tick(1);
        chk_notes("t1.idle", 0, 0, 0, 0);

        // 2: 3-cycle glitch is rejected, 4-cycle hold accepted
        glitch_seen = 0;
        keys[7] = 1'b1;
        tick(3);
        keys[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (keycode != 0 || strobe || press || release_p) glitch_seen = 1;
        end
        chk("t2.glitch", glitch_seen, 0);
        keys[7] = 1'b1;
        tick(5);
        chk_notes("t2.on", 8, 1, 1, 0);
        keys[7] = 1'b0;
        tick(5);
        chk_notes("t2.off", 0, 0, 0, 1);

        // 3: priority, re-encode on release of the higher key, distinct codes
        keys[2] = 1'b1;
        tick(5);
        chk_notes("t3.k2", 3, 1, 1, 0);
        keys[16] = 1'b1;
        tick(5);
        chk_notes("t3.k16", 17, 1, 1, 0);
        tick(1);
        chk_notes("t3.k16h", 17, 1, 0, 0);
        keys[16] = 1'b0;
        tick(5);
        chk_notes("t3.back", 3, 1, 1, 0);
        keys = '0;
        keys[5] = 1'b1;
        tick(5);
        chk_notes("t3.k5", 6, 1, 1, 0);
        keys = '0;
        keys[6] = 1'b1;
        tick(5);
        chk_notes("t3.k6", 7, 1, 1, 0);
        keys = '0;
        tick(5);
        chk_notes("t3.off", 0, 0, 0, 1);

        // 4: octave saturation, simultaneous edges, no auto-repeat
        exp_oct = 4;
        for (int i = 0; i < 5; i++) begin
            press_up();
            exp_oct = (exp_oct < 7) ? exp_oct + 1 : 7;
            chk("t4.up", int'(octave), exp_oct);
        end
        for (int i = 0; i < 9; i++) begin
            press_dn();
            exp_oct = (exp_oct > 0) ? exp_oct - 1 : 0;
            chk("t4.dn", int'(octave), exp_oct);
        end
        press_up();
        chk("t4.up1", int'(octave), 1);
        up = 1'b1; dn = 1'b1;
        tick(5);
        up = 1'b0; dn = 1'b0;
        tick(5);
        chk("t4.both", int'(octave), 1);
        up = 1'b1;
        tick(100);
        chk("t4.hold", int'(octave), 2);
        up = 1'b0;
        tick(5);
        chk("t4.holdrel", int'(octave), 2);

        // 5: mode wraps; held note is undisturbed
        keys[9] = 1'b1;
        tick(5);
        chk_notes("t5.k9", 10, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            press_md();
            chk("t5.mode", int'(mode), (i + 1) % 4);
            chk_notes("t5.note", 10, 1, 0, 0);
        end

        // 6: reset while a key is held
        keys = '0;
        keys[3] = 1'b1;
        tick(5);
        chk_notes("t6.k3", 4, 1, 1, 0);
        rst = 1'b1;
        tick(2);
        chk_notes("t6.rst", 0, 0, 0, 0);
        chk("t6.rst.octave", int'(octave), 4);
        chk("t6.rst.mode", int'(mode), 0);
        rst = 1'b0;
        tick(4);
        chk_notes("t6.pre", 0, 0, 0, 0);
        tick(1);
        chk_notes("t6.on", 4, 1, 1, 0);
        tick(1);
        chk_notes("t6.hold", 4, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
